sram_1rw_ctrl: RTL and testbench

Front-end controller for a single-port 1024×384 masked-write SRAM macro with 16 lanes of 24 bits and 1-cycle read latency. It sits directly upstream of the macro and owns its single RW port. It zero-fills the array after reset, arbitrates independent write and read request channels onto the port, and returns read data through a credit-controlled response buffer with valid/ready back-pressure.

---
 rtl/sram_ctrl_pkg.sv | 25 ++
 rtl/sram_resp_fifo.sv | 55 +++++
 rtl/sram_1rw_ctrl.sv | 147 ++++++++++++++
 tb/tb_sram_1rw_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM front-end.
// Geometry of the 1024x384 masked-write macro.
package sram_ctrl_pkg;

  localparam int SET_BITS  = 10;
  localparam int LANES     = 16;
  localparam int LANE_BITS = 24;
  localparam int DATA_BITS = LANES * LANE_BITS;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  typedef struct packed {
    logic [SET_BITS-1:0]  addr;
    logic [LANES-1:0]     mask;
    logic [DATA_BITS-1:0] data;
  } wr_req_t;

  typedef struct packed {
    logic [SET_BITS-1:0] addr;
  } rd_req_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// Read-response FIFO; head is taken straight from the storage flops.
// Overflow is prevented upstream by the credit rule.
module sram_resp_fifo #(
  parameter int  DEPTH = 3,
  parameter int  WIDTH = 384,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sram_1rw_ctrl.sv
// Front-end for a 1RW masked-write SRAM: zero-fill sweep,
// write/read arbitration and credit-limited read responses.
module sram_1rw_ctrl #(
  parameter int  SET_BITS      = sram_ctrl_pkg::SET_BITS,
  parameter int  LANES         = sram_ctrl_pkg::LANES,
  parameter int  LANE_BITS     = sram_ctrl_pkg::LANE_BITS,
  parameter int  RESP_DEPTH    = 3,
  parameter bit  INIT_ON_RESET = 1'b1,
  localparam int DW            = LANES * LANE_BITS,
  localparam int CW            = $clog2(RESP_DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [SET_BITS-1:0] w_addr,
  input  logic [LANES-1:0]    w_mask,
  input  logic [DW-1:0]       w_data,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [SET_BITS-1:0] r_addr,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DW-1:0]       resp_data,
  output logic                init_done,
  output logic [SET_BITS-1:0] sram_addr,
  output logic                sram_en,
  output logic                sram_wmode,
  output logic [LANES-1:0]    sram_wmask,
  output logic [DW-1:0]       sram_wdata,
  input  logic [DW-1:0]       sram_rdata
);

  import sram_ctrl_pkg::*;

  state_e              state_q;
  state_e              state_d;
  logic                armed_q;
  logic [SET_BITS-1:0] sweep_q;
  logic                last_w_q;
  logic                inflight_q;
  logic [SET_BITS-1:0] addr_q;
  logic [LANES-1:0]    mask_q;
  logic [DW-1:0]       wdata_q;
  logic [CW-1:0]       fifo_count;
  logic                fifo_empty;
  logic                run;
  logic                init_act;
  logic                credit;
  logic                pick_r;
  logic                gnt_w;
  logic                gnt_r;

  // armed_q keeps the port quiet until the first edge after reset
  assign run      = armed_q && (state_q == RUN);
  assign init_act = armed_q && (state_q == INIT);

  assign credit =
    ({1'b0, fifo_count} + (CW + 1)'(inflight_q))
    < (CW + 1)'(RESP_DEPTH);

  // read wins a tie only when the previous grant was a write
  assign pick_r = r_valid && credit && (!w_valid || last_w_q);
  assign gnt_r  = run && pick_r;
  assign gnt_w  = run && w_valid && !pick_r;

  assign w_ready    = run && !pick_r;
  assign r_ready    = run && credit && (!w_valid || last_w_q);
  assign init_done  = run;
  assign resp_valid = !fifo_empty;

  always_comb begin
    state_d = state_q;
    if (init_act && (sweep_q == '1))
      state_d = RUN;
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = addr_q;
    sram_wmask = mask_q;
    sram_wdata = wdata_q;
    unique case (1'b1)
      init_act: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = sweep_q;
        sram_wmask = '1;
        sram_wdata = '0;
      end
      gnt_w: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = w_addr;
        sram_wmask = w_mask;
        sram_wdata = w_data;
      end
      gnt_r: begin
        sram_en   = 1'b1;
        sram_addr = r_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT_ON_RESET ? INIT : RUN;
      armed_q    <= 1'b0;
      sweep_q    <= '0;
      last_w_q   <= 1'b0;
      inflight_q <= 1'b0;
      addr_q     <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
    end else begin
      armed_q    <= 1'b1;
      state_q    <= state_d;
      inflight_q <= gnt_r;
      if (init_act && (sweep_q != '1))
        sweep_q <= sweep_q + 1'b1;
      if (gnt_w || gnt_r)
        last_w_q <= gnt_w;
      if (sram_en) begin
        addr_q  <= sram_addr;
        mask_q  <= sram_wmask;
        wdata_q <= sram_wdata;
      end
    end
  end

  sram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (inflight_q),
    .pop     (resp_valid && resp_ready),
    .wdata   (sram_rdata),
    .head    (resp_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_sram_1rw_ctrl.sv
// Scoreboard bench for sram_1rw_ctrl with a behavioural macro
// and an array-based reference of the memory contents.
module tb_sram_1rw_ctrl;

  localparam int SB = 10;
  localparam int LN = 16;
  localparam int LB = 24;
  localparam int DW = LN * LB;
  localparam int NS = 1024;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [SB-1:0] w_addr = '0;
  logic [LN-1:0] w_mask = '0;
  logic [DW-1:0] w_data = '0;
  logic          r_valid = 1'b0;
  logic          r_ready;
  logic [SB-1:0] r_addr = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_data;
  logic          init_done;
  logic [SB-1:0] sram_addr;
  logic          sram_en;
  logic          sram_wmode;
  logic [LN-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  always #5 clock = ~clock;

  sram_1rw_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_addr     (w_addr),
    .w_mask     (w_mask),
    .w_data     (w_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_addr     (r_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .init_done  (init_done),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++)
      d[i*32 +: 32] = $urandom | 32'h1;
    return d;
  endfunction

  // behavioural macro, starting from garbage
  bit            fill_garbage = 1'b1;
  logic [DW-1:0] macro [NS];

  always @(posedge clock) begin
    if (fill_garbage) begin
      for (int s = 0; s < NS; s++)
        macro[s] <= rnd_data();
    end else if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < LN; l++)
          if (sram_wmask[l])
            macro[sram_addr][l*LB +: LB] <= sram_wdata[l*LB +: LB];
      end else begin
        sram_rdata <= macro[sram_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // reference model and scoreboard
  logic [DW-1:0] ref_mem [NS];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] rsp_log [$];
  int            rsp_cyc [$];
  bit            gnt_log [$];
  int            nrd = 0;
  bit            last_rd = 1'b1;

  initial forever begin
    @(negedge clock);
    if (!reset_n) begin
      exp_q.delete();
      for (int s = 0; s < NS; s++) ref_mem[s] = '0;
      last_rd = 1'b1;
    end else begin
      if (w_valid && r_valid)
        chk("single_grant", DW'(w_ready && r_ready), '0);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0)
          chk("resp_unexpected", DW'(1), '0);
        else
          chk("resp_data", resp_data, exp_q.pop_front());
        rsp_log.push_back(resp_data);
        rsp_cyc.push_back(cyc);
      end
      if (r_valid && r_ready) begin
        exp_q.push_back(ref_mem[r_addr]);
        gnt_log.push_back(1'b1);
        last_rd = 1'b1;
        nrd++;
      end
      if (w_valid && w_ready) begin
        for (int l = 0; l < LN; l++)
          if (w_mask[l]) ref_mem[w_addr][l*LB +: LB] = w_data[l*LB +: LB];
        gnt_log.push_back(1'b0);
        last_rd = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [SB-1:0] a, input logic [LN-1:0] m,
                    input logic [DW-1:0] d);
    bit ok = 1'b0;
    w_addr = a; w_mask = m; w_data = d; w_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      ok = w_ready;
      tick();
    end
    w_valid = 1'b0;
    if (!ok) chk("wr_timeout", DW'(0), DW'(1));
  endtask

  task automatic rd(input logic [SB-1:0] a);
    bit ok = 1'b0;
    r_addr = a; r_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      ok = r_ready;
      tick();
    end
    r_valid = 1'b0;
    if (!ok) chk("rd_timeout", DW'(0), DW'(1));
  endtask

  task automatic drain();
    bit ok = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clock);
      ok = (exp_q.size() == 0) && !resp_valid;
      tick();
    end
    if (!ok) chk("drain_timeout", DW'(exp_q.size()), '0);
  endtask

  // counts sweep writes and init_done timing after a reset release
  task automatic check_sweep(input string nm);
    int n_wr = 0, bad = 0, done_at = 0;
    for (int k = 1; k <= 1100 && done_at == 0; k++) begin
      @(negedge clock);
      if (k <= 1024) begin
        if (sram_en && sram_wmode && sram_addr == SB'(k - 1) &&
            sram_wmask == '1 && sram_wdata == '0)
          n_wr++;
        if (w_ready || r_ready) bad++;
      end
      if (resp_valid) bad++;
      if (init_done) done_at = k;
    end
    chk({nm, "_writes"}, DW'(n_wr), DW'(1024));
    chk({nm, "_quiet"}, DW'(bad), '0);
    chk({nm, "_done_cycle"}, DW'(done_at), DW'(1025));
    tick();
  endtask

  initial begin
    logic [DW-1:0] e;
    bit   exp_pat [$];
    bit   nxt_rd;
    int   nw, nr, n0, used, idx;

    repeat (3) @(posedge clock);
    fill_garbage = 1'b0;
    @(negedge clock);
    chk("rst_w_ready", DW'(w_ready), '0);
    chk("rst_r_ready", DW'(r_ready), '0);
    chk("rst_resp_valid", DW'(resp_valid), '0);
    chk("rst_init_done", DW'(init_done), '0);
    chk("rst_sram_en", DW'(sram_en), '0);
    reset_n = 1'b1;
    check_sweep("init");

    rd(SB'(517));
    drain();
    chk("read_517", rsp_log[$], '0);

    // masked write then read-back latency
    wr(SB'(5), 16'h0001, '1);
    rd(SB'(5));
    @(negedge clock);
    chk("lat_n1_valid", DW'(resp_valid), '0);
    @(negedge clock);
    chk("lat_n2_valid", DW'(resp_valid), DW'(1));
    e = '0;
    e[23:0] = 24'hFFFFFF;
    chk("masked_data", resp_data, e);
    tick();
    drain();

    // contention: round-robin from the model's last grant
    gnt_log.delete();
    exp_pat.delete();
    nxt_rd = !last_rd;
    for (int i = 0; i < 8; i++) begin
      exp_pat.push_back(nxt_rd);
      nxt_rd = !nxt_rd;
    end
    for (int i = 0; i < 8; i++) begin
      w_valid = 1'b1; r_valid = 1'b1;
      w_addr = SB'($urandom_range(0, 31));
      r_addr = SB'($urandom_range(0, 31));
      w_mask = LN'($urandom);
      w_data = rnd_data();
      @(negedge clock);
      tick();
    end
    w_valid = 1'b0; r_valid = 1'b0;
    nw = 0; nr = 0;
    foreach (gnt_log[i]) if (gnt_log[i]) nr++; else nw++;
    chk("cont_writes", DW'(nw), DW'(4));
    chk("cont_reads", DW'(nr), DW'(4));
    idx = 0;
    foreach (gnt_log[i])
      if (i < 8 && gnt_log[i] != exp_pat[i]) idx++;
    chk("cont_alternate", DW'(idx), '0);
    drain();

    // back-pressure
    resp_ready = 1'b0;
    n0 = nrd;
    for (int i = 0; i < 8; i++) begin
      r_valid = 1'b1;
      r_addr = SB'($urandom_range(0, 31));
      @(negedge clock);
      tick();
    end
    chk("bp_reads", DW'(nrd - n0), DW'(3));
    @(negedge clock);
    chk("bp_r_ready", DW'(r_ready), '0);
    tick();
    wr(SB'(7), '1, rnd_data());
    chk("bp_write_no_read", DW'(nrd - n0), DW'(3));
    r_valid = 1'b0;
    drain();
    @(negedge clock);
    chk("bp_resume_ready", DW'(r_ready), DW'(1));
    tick();
    rd(SB'(7));
    drain();

    // throughput
    for (int i = 0; i < 16; i++) wr(SB'(i), '1, DW'(i));
    rsp_log.delete();
    rsp_cyc.delete();
    idx = 0; used = 0;
    while (idx < 16 && used < 40) begin
      r_valid = 1'b1;
      r_addr = SB'(idx);
      @(negedge clock);
      if (r_ready) idx++;
      used++;
      tick();
    end
    r_valid = 1'b0;
    chk("tp_cycles", DW'(used), DW'(16));
    drain();
    chk("tp_count", DW'(rsp_log.size()), DW'(16));
    if (rsp_log.size() == 16) begin
      nw = 0;
      for (int j = 0; j < 16; j++) if (rsp_log[j] != DW'(j)) nw++;
      chk("tp_values", DW'(nw), '0);
      chk("tp_span", DW'(rsp_cyc[15] - rsp_cyc[0]), DW'(15));
    end

    // random traffic
    for (int i = 0; i < 300; i++) begin
      w_valid = 1'($urandom);
      r_valid = 1'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      w_addr = SB'($urandom_range(0, 15));
      r_addr = SB'($urandom_range(0, 15));
      w_mask = LN'($urandom);
      w_data = rnd_data();
      @(negedge clock);
      tick();
    end
    w_valid = 1'b0; r_valid = 1'b0;
    drain();

    // reset with two queued responses and one in flight
    wr(SB'(5), '1, rnd_data());
    resp_ready = 1'b0;
    n0 = nrd;
    r_addr = SB'(5);
    for (int i = 0; i < 20 && (nrd - n0) < 3; i++) begin
      r_valid = 1'b1;
      @(negedge clock);
      tick();
    end
    r_valid = 1'b0;
    chk("mr_pre_valid", DW'(resp_valid), DW'(1));
    #1 reset_n = 1'b0;
    #1 chk("mr_resp_valid", DW'(resp_valid), '0);
    repeat (2) @(posedge clock);
    resp_ready = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    check_sweep("reinit");
    rd(SB'(5));
    drain();
    chk("mr_read_zero", rsp_log[$], '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
